// File: rtl/elevator_dispatcher.sv
// elevator_dispatcher: single-car SCAN (collective) dispatcher with one-hot car position and door dwell.
// Optional home return to floor 1 after a long idle period is built when ELEVATOR_HOME_RETURN_EN is defined.
module elevator_dispatcher #(
  parameter int FLOORS     = 10,
  parameter int DOOR_TICKS = 5,
  parameter int HOME_TICKS = 8
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              tick,
  input  logic              req_valid,
  input  logic [3:0]        req_floor,
  output logic [FLOORS-1:0] cur_floor,
  output logic [FLOORS-1:0] floor_reg,
  output logic [1:0]        state,
  output logic              direction,
  output logic              arrive
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b01,
    ST_BUSY   = 2'b10,
    ST_TRAVEL = 2'b11
  } state_t;

  localparam logic              DIR_UP    = 1'b1;
  localparam logic              DIR_DOWN  = 1'b0;
  localparam logic [3:0]        DOOR_LAST = 4'(DOOR_TICKS - 1);
  localparam logic [FLOORS-1:0] FLOOR_ONE = {{(FLOORS-1){1'b0}}, 1'b1};
  localparam logic [FLOORS-1:0] NO_FLOOR  = {FLOORS{1'b0}};

  state_t            state_r, state_nx;
  logic [FLOORS-1:0] cur_floor_r, cur_nx;
  logic [FLOORS-1:0] floor_reg_r, floor_nx;
  logic              direction_r, dir_nx;
  logic              arrive_r, arrive_nx;
  logic [3:0]        door_cnt_r, door_nx;

  logic [FLOORS-1:0] req_mask_s, absorb_s, lower_mask_s, upper_mask_s, clear_s, home_set_s;
  logic              above_s, below_s, here_s, ahead_s, behind_s, rereq_s;

  // Decode the binary request into a one-hot mask; 0 and out-of-range floors match no bit
  always_comb begin
    req_mask_s = NO_FLOOR;
    for (int i = 0; i < FLOORS; i++) begin
      req_mask_s[i] = req_valid && (req_floor == 4'(i + 1));
    end
  end

  // Subtracting one from a one-hot value yields exactly the floors below the car
  assign lower_mask_s = cur_floor_r - FLOOR_ONE;
  assign upper_mask_s = ~(lower_mask_s | cur_floor_r);
  assign above_s      = |(floor_reg_r & upper_mask_s);
  assign below_s      = |(floor_reg_r & lower_mask_s);
  assign here_s       = |(floor_reg_r & cur_floor_r);
  assign ahead_s      = (direction_r == DIR_UP) ? above_s : below_s;
  assign behind_s     = (direction_r == DIR_UP) ? below_s : above_s;
  assign rereq_s      = (state_r == ST_BUSY) && (|(req_mask_s & cur_floor_r));
  assign absorb_s     = (state_r == ST_BUSY) ? cur_floor_r : NO_FLOOR;

  // Next-state, car movement, door timer and pending-request update
  always_comb begin
    state_nx  = state_r;
    dir_nx    = direction_r;
    cur_nx    = cur_floor_r;
    door_nx   = door_cnt_r;
    arrive_nx = 1'b0;
    clear_s   = NO_FLOOR;
    case (state_r)
      ST_IDLE: begin
        if (here_s) begin
          state_nx = ST_BUSY;
        end else if (above_s && ((direction_r == DIR_UP) || !below_s)) begin
          dir_nx   = DIR_UP;
          state_nx = ST_TRAVEL;
        end else if (below_s) begin
          dir_nx   = DIR_DOWN;
          state_nx = ST_TRAVEL;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_TRAVEL: begin
        if (here_s) begin
          state_nx = ST_BUSY;
        end else if (!ahead_s) begin
          state_nx = ST_IDLE;
        end else if (tick) begin
          if (direction_r == DIR_UP) begin
            cur_nx = cur_floor_r[FLOORS-1] ? cur_floor_r : {cur_floor_r[FLOORS-2:0], 1'b0};
          end else begin
            cur_nx = cur_floor_r[0] ? cur_floor_r : {1'b0, cur_floor_r[FLOORS-1:1]};
          end
        end else begin
          cur_nx = cur_floor_r;
        end
      end
      ST_BUSY: begin
        if (rereq_s) begin
          door_nx = 4'd0;
        end else if (tick) begin
          if (door_cnt_r == DOOR_LAST) begin
            door_nx = 4'd0;
            if (ahead_s) begin
              state_nx = ST_TRAVEL;
            end else if (behind_s) begin
              dir_nx   = ~direction_r;
              state_nx = ST_TRAVEL;
            end else begin
              state_nx = ST_IDLE;
            end
          end else begin
            door_nx = door_cnt_r + 4'd1;
          end
        end else begin
          door_nx = door_cnt_r;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    // Service stop: the clear wins over a same-cycle request for this floor
    if ((state_nx == ST_BUSY) && (state_r != ST_BUSY)) begin
      arrive_nx = 1'b1;
      door_nx   = 4'd0;
      clear_s   = cur_floor_r;
    end else begin
      clear_s   = NO_FLOOR;
    end
    floor_nx = (floor_reg_r | (req_mask_s & ~absorb_s) | home_set_s) & ~clear_s;
  end

`ifdef ELEVATOR_HOME_RETURN_EN
  localparam logic [3:0] HOME_LAST = 4'(HOME_TICKS - 1);
  logic [3:0] idle_cnt_r, idle_nx;

  // Idle timer runs only while parked away from floor 1 with nothing pending or arriving
  always_comb begin
    idle_nx    = idle_cnt_r;
    home_set_s = NO_FLOOR;
    if ((state_r != ST_IDLE) || (floor_reg_r != NO_FLOOR) || (|req_mask_s) || cur_floor_r[0]) begin
      idle_nx = 4'd0;
    end else if (tick) begin
      if (idle_cnt_r == HOME_LAST) begin
        idle_nx    = 4'd0;
        home_set_s = FLOOR_ONE;
      end else begin
        idle_nx = idle_cnt_r + 4'd1;
      end
    end else begin
      idle_nx = idle_cnt_r;
    end
  end

  // Idle timer register
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      idle_cnt_r <= 4'd0;
    end else begin
      idle_cnt_r <= idle_nx;
    end
  end
`else
  assign home_set_s = NO_FLOOR;
`endif

  // State and datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cur_floor_r <= FLOOR_ONE;
      floor_reg_r <= NO_FLOOR;
      direction_r <= DIR_UP;
      arrive_r    <= 1'b0;
      door_cnt_r  <= 4'd0;
    end else begin
      state_r     <= state_nx;
      cur_floor_r <= cur_nx;
      floor_reg_r <= floor_nx;
      direction_r <= dir_nx;
      arrive_r    <= arrive_nx;
      door_cnt_r  <= door_nx;
    end
  end

  assign cur_floor = cur_floor_r;
  assign floor_reg = floor_reg_r;
  assign state     = state_r;
  assign direction = direction_r;
  assign arrive    = arrive_r;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed self-checking bench for elevator_dispatcher; the home-return scenario follows ELEVATOR_HOME_RETURN_EN.
module tb_elevator_dispatcher;

  localparam logic [1:0] S_IDLE = 2'b01;
  localparam logic [1:0] S_BUSY = 2'b10;
  localparam logic [1:0] S_TRAV = 2'b11;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_floor = 4'd0;
  logic [9:0] cur_floor, floor_reg;
  logic [1:0] state;
  logic       direction, arrive;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  elevator_dispatcher dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .tick     (tick),
    .req_valid(req_valid),
    .req_floor(req_floor),
    .cur_floor(cur_floor),
    .floor_reg(floor_reg),
    .state    (state),
    .direction(direction),
    .arrive   (arrive)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic pulse_tick(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
    end
  endtask

  task automatic request(input logic [3:0] f);
    req_valid = 1'b1;
    req_floor = f;
    cyc(1);
    req_valid = 1'b0;
    req_floor = 4'd0;
  endtask

  function automatic logic [9:0] oh(input int f);
    logic [9:0] one;
    one = 10'd1;
    return one << (f - 1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    n_cmp++; if (cur_floor !== 10'b0000000001) begin n_bad++; $display("FAIL reset_cur: got %b want %b", cur_floor, 10'b0000000001); end
    n_cmp++; if (floor_reg !== 10'b0) begin n_bad++; $display("FAIL reset_reg: got %b want 0", floor_reg); end
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %b want %b", state, S_IDLE); end
    n_cmp++; if (direction !== 1'b1) begin n_bad++; $display("FAIL reset_dir: got %b want 1", direction); end
    n_cmp++; if (arrive !== 1'b0) begin n_bad++; $display("FAIL reset_arrive: got %b want 0", arrive); end
  endtask

  task automatic test_invalid();
    request(4'd0);
    n_cmp++; if (floor_reg !== 10'b0) begin n_bad++; $display("FAIL inv0_reg: got %b want 0", floor_reg); end
    cyc(1);
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL inv0_state: got %b want %b", state, S_IDLE); end
    request(4'd12);
    n_cmp++; if (floor_reg !== 10'b0) begin n_bad++; $display("FAIL inv12_reg: got %b want 0", floor_reg); end
    cyc(1);
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL inv12_state: got %b want %b", state, S_IDLE); end
    request(4'd1);
    n_cmp++; if (floor_reg !== oh(1)) begin n_bad++; $display("FAIL here_reg: got %b want %b", floor_reg, oh(1)); end
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL here_state1: got %b want %b", state, S_IDLE); end
    cyc(1);
    n_cmp++; if (state !== S_BUSY || arrive !== 1'b1) begin n_bad++; $display("FAIL here_busy: got state %b arrive %b want %b 1", state, arrive, S_BUSY); end
    n_cmp++; if (floor_reg !== 10'b0) begin n_bad++; $display("FAIL here_clear: got %b want 0", floor_reg); end
    pulse_tick(5);
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL here_done: got %b want %b", state, S_IDLE); end
  endtask

  task automatic test_basic();
    request(4'd4);
    n_cmp++; if (floor_reg !== 10'b0000001000) begin n_bad++; $display("FAIL basic_reg: got %b want %b", floor_reg, 10'b0000001000); end
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL basic_wait: got %b want %b", state, S_IDLE); end
    cyc(1);
    n_cmp++; if (state !== S_TRAV || direction !== 1'b1) begin n_bad++; $display("FAIL basic_start: got %b/%b want %b/1", state, direction, S_TRAV); end
    for (int f = 2; f <= 4; f++) begin
      pulse_tick(1);
      n_cmp++; if (cur_floor !== oh(f) || state !== S_TRAV) begin n_bad++; $display("FAIL basic_move: got %b/%b want %b/%b", cur_floor, state, oh(f), S_TRAV); end
    end
    cyc(1);
    n_cmp++; if (state !== S_BUSY || arrive !== 1'b1 || floor_reg !== 10'b0) begin n_bad++; $display("FAIL basic_arrive: got %b/%b/%b", state, arrive, floor_reg); end
    cyc(1);
    n_cmp++; if (arrive !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: got %b want 0", arrive); end
    pulse_tick(4);
    n_cmp++; if (state !== S_BUSY) begin n_bad++; $display("FAIL basic_dwell: got %b want %b", state, S_BUSY); end
    pulse_tick(1);
    n_cmp++; if (state !== S_IDLE || direction !== 1'b1) begin n_bad++; $display("FAIL basic_idle: got %b/%b want %b/1", state, direction, S_IDLE); end
  endtask

  task automatic test_sweep();
    request(4'd5);
    cyc(1);
    pulse_tick(1);
    cyc(1);
    n_cmp++; if (state !== S_BUSY || cur_floor !== oh(5)) begin n_bad++; $display("FAIL sweep_at5: got %b/%b", state, cur_floor); end
    request(4'd8);
    request(4'd2);
    n_cmp++; if (floor_reg !== (oh(8) | oh(2))) begin n_bad++; $display("FAIL sweep_reg: got %b want %b", floor_reg, oh(8) | oh(2)); end
    pulse_tick(5);
    n_cmp++; if (state !== S_TRAV || direction !== 1'b1) begin n_bad++; $display("FAIL sweep_up: got %b/%b want %b/1", state, direction, S_TRAV); end
    for (int f = 6; f <= 8; f++) begin
      pulse_tick(1);
      n_cmp++; if (cur_floor !== oh(f) || state !== S_TRAV) begin n_bad++; $display("FAIL sweep_upmove: got %b/%b want %b", cur_floor, state, oh(f)); end
    end
    cyc(1);
    n_cmp++; if (state !== S_BUSY || arrive !== 1'b1 || floor_reg !== oh(2)) begin n_bad++; $display("FAIL sweep_at8: got %b/%b/%b", state, arrive, floor_reg); end
    pulse_tick(5);
    n_cmp++; if (state !== S_TRAV || direction !== 1'b0) begin n_bad++; $display("FAIL sweep_rev: got %b/%b want %b/0", state, direction, S_TRAV); end
    for (int f = 7; f >= 2; f--) begin
      pulse_tick(1);
      n_cmp++; if (cur_floor !== oh(f) || state !== S_TRAV) begin n_bad++; $display("FAIL sweep_dnmove: got %b/%b want %b", cur_floor, state, oh(f)); end
    end
    cyc(1);
    n_cmp++; if (state !== S_BUSY || cur_floor !== oh(2) || floor_reg !== 10'b0) begin n_bad++; $display("FAIL sweep_at2: got %b/%b/%b", state, cur_floor, floor_reg); end
    pulse_tick(5);
    n_cmp++; if (state !== S_IDLE || direction !== 1'b0) begin n_bad++; $display("FAIL sweep_idle: got %b/%b want %b/0", state, direction, S_IDLE); end
  endtask

  task automatic test_rereq();
    request(4'd6);
    cyc(1);
    n_cmp++; if (state !== S_TRAV || direction !== 1'b1) begin n_bad++; $display("FAIL rereq_start: got %b/%b want %b/1", state, direction, S_TRAV); end
    pulse_tick(4);
    cyc(1);
    n_cmp++; if (state !== S_BUSY || cur_floor !== oh(6)) begin n_bad++; $display("FAIL rereq_at6: got %b/%b", state, cur_floor); end
    pulse_tick(3);
    request(4'd6);
    n_cmp++; if (floor_reg !== 10'b0 || state !== S_BUSY) begin n_bad++; $display("FAIL rereq_absorb: got %b/%b", floor_reg, state); end
    pulse_tick(4);
    n_cmp++; if (state !== S_BUSY) begin n_bad++; $display("FAIL rereq_hold: got %b want %b", state, S_BUSY); end
    pulse_tick(1);
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL rereq_exit: got %b want %b", state, S_IDLE); end
  endtask

  task automatic test_reset_mid_travel();
    request(4'd3);
    request(4'd9);
    pulse_tick(1);
    n_cmp++; if (state !== S_TRAV || cur_floor !== oh(5)) begin n_bad++; $display("FAIL mid_pre: got %b/%b", state, cur_floor); end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    n_cmp++; if (cur_floor !== oh(1) || floor_reg !== 10'b0) begin n_bad++; $display("FAIL mid_pos: got %b/%b", cur_floor, floor_reg); end
    n_cmp++; if (state !== S_IDLE || direction !== 1'b1 || arrive !== 1'b0) begin n_bad++; $display("FAIL mid_ctl: got %b/%b/%b", state, direction, arrive); end
    cyc(3);
    n_cmp++; if (state !== S_IDLE || cur_floor !== oh(1)) begin n_bad++; $display("FAIL mid_after: got %b/%b", state, cur_floor); end
  endtask

  task automatic test_home();
    request(4'd7);
    cyc(1);
    pulse_tick(6);
    cyc(1);
    n_cmp++; if (state !== S_BUSY || cur_floor !== oh(7)) begin n_bad++; $display("FAIL home_at7: got %b/%b", state, cur_floor); end
    pulse_tick(5);
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL home_idle: got %b want %b", state, S_IDLE); end
`ifdef ELEVATOR_HOME_RETURN_EN
    pulse_tick(7);
    n_cmp++; if (floor_reg !== 10'b0) begin n_bad++; $display("FAIL home_early: got %b want 0", floor_reg); end
    pulse_tick(1);
    n_cmp++; if (floor_reg !== oh(1)) begin n_bad++; $display("FAIL home_inject: got %b want %b", floor_reg, oh(1)); end
    cyc(1);
    n_cmp++; if (state !== S_TRAV || direction !== 1'b0) begin n_bad++; $display("FAIL home_down: got %b/%b want %b/0", state, direction, S_TRAV); end
    pulse_tick(6);
    cyc(1);
    n_cmp++; if (state !== S_BUSY || cur_floor !== oh(1) || arrive !== 1'b1) begin n_bad++; $display("FAIL home_at1: got %b/%b/%b", state, cur_floor, arrive); end
`else
    pulse_tick(20);
    n_cmp++; if (floor_reg !== 10'b0) begin n_bad++; $display("FAIL nohome_reg: got %b want 0", floor_reg); end
    n_cmp++; if (state !== S_IDLE || cur_floor !== oh(7)) begin n_bad++; $display("FAIL nohome_park: got %b/%b", state, cur_floor); end
`endif
  endtask

  initial begin
    test_reset();
    test_invalid();
    test_basic();
    test_sweep();
    test_rereq();
    test_reset_mid_travel();
    test_home();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
